// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-stage bus: program memory, decode hand-off and redirect signals
interface instruction_fetch_if;
    logic [31:0] o_pc;
    logic        o_instruction_request;
    logic [31:0] i_instruction;
    logic        i_awk;
    logic [31:0] o_if_instruction;
    logic [31:0] o_if_pc;
    logic        o_if_valid;
    logic        i_id_ready;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_misalign;
    logic [31:0] o_fetch_count;

    modport master (
        output o_pc, o_instruction_request, o_if_instruction, o_if_pc, o_if_valid,
               o_misalign, o_fetch_count,
        input  i_instruction, i_awk, i_id_ready, i_stall, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_pc, o_instruction_request, o_if_instruction, o_if_pc, o_if_valid,
               o_misalign, o_fetch_count,
        output i_instruction, i_awk, i_id_ready, i_stall, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-entry instruction fetch stage; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    instruction_fetch_if.master   bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL, S_TRAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        request;

    // Redirect must kill the request in the same cycle so memory never sees a stale address.
    assign request = (state_q == S_REQ) && !bus.i_stall && !bus.i_redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign bus.o_misalign = misalign_q;
`else
    assign bus.o_misalign = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
`endif
        if (bus.i_redirect) begin
            if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d = bus.i_redirect_pc;
            if (bus.i_redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = S_TRAP;
            end else begin
                misalign_d = 1'b0;
                state_d    = S_REQ;
            end
`else
            pc_d    = bus.i_redirect_pc & 32'hFFFF_FFFC;
            state_d = S_REQ;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (!bus.i_stall) state_d = S_REQ;
                S_REQ: begin
                    if (request && bus.i_awk) begin
                        if_instr_d = bus.i_instruction;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_FULL;
                    end
                end
                S_FULL: begin
                    if (bus.i_id_ready && !bus.i_stall) begin
                        if_valid_d    = 1'b0;
                        fetch_count_d = fetch_count_q + 32'd1;
                        state_d       = S_REQ;
                    end
                end
                S_TRAP: state_d = S_TRAP;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            if_instr_q    <= NOP;
            if_pc_q       <= 32'd0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    assign bus.o_pc                  = pc_q;
    assign bus.o_instruction_request = request;
    assign bus.o_if_instruction      = if_instr_q;
    assign bus.o_if_pc               = if_pc_q;
    assign bus.o_if_valid            = if_valid_q;
    assign bus.o_fetch_count         = fetch_count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.i_instruction = 32'h0;
        bus.i_awk         = 1'b0;
        bus.i_id_ready    = 1'b0;
        bus.i_stall       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        tick();
        // reset overrides a simultaneous redirect and ack
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0500; bus.i_awk = 1'b1;
        tick();
        bus.i_redirect = 1'b0; bus.i_awk = 1'b0;
        #1;
        check("rst_pc",      bus.o_pc, 32'h100);
        check("rst_valid",   {31'd0, bus.o_if_valid}, 32'd0);
        check("rst_instr",   bus.o_if_instruction, 32'h13);
        check("rst_if_pc",   bus.o_if_pc, 32'h0);
        check("rst_mis",     {31'd0, bus.o_misalign}, 32'd0);
        check("rst_count",   bus.o_fetch_count, 32'd0);
        check("rst_req",     {31'd0, bus.o_instruction_request}, 32'd0);

        // streaming: ack and accept always high, one instruction per two cycles
        rst_n = 1'b1; bus.i_awk = 1'b1; bus.i_id_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.i_instruction = 32'hA000_0000 + k;
            #1;
            check("str_req",   {31'd0, bus.o_instruction_request}, 32'd1);
            check("str_pc",    bus.o_pc, 32'h100 + 4 * k);
            check("str_vlo",   {31'd0, bus.o_if_valid}, 32'd0);
            tick();
            check("str_vhi",   {31'd0, bus.o_if_valid}, 32'd1);
            check("str_instr", bus.o_if_instruction, 32'hA000_0000 + k);
            check("str_ifpc",  bus.o_if_pc, 32'h100 + 4 * k);
            check("str_noreq", {31'd0, bus.o_instruction_request}, 32'd0);
            tick();
            check("str_count", bus.o_fetch_count, k + 1);
        end

        // memory wait: request and address held while ack is low
        bus.i_awk = 1'b0; bus.i_instruction = 32'hBEEF_0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("wait_req", {31'd0, bus.o_instruction_request}, 32'd1);
            check("wait_pc",  bus.o_pc, 32'h10C);
            tick();
            check("wait_vld", {31'd0, bus.o_if_valid}, 32'd0);
        end
        bus.i_awk = 1'b1; bus.i_id_ready = 1'b0;
        tick();
        check("wait_cap",   bus.o_if_instruction, 32'hBEEF_0001);
        check("wait_ifpc",  bus.o_if_pc, 32'h10C);
        check("wait_pc2",   bus.o_pc, 32'h110);

        // decode back-pressure; stray acks in S_FULL ignored
        bus.i_instruction = 32'hDEAD_DEAD;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_instr", bus.o_if_instruction, 32'hBEEF_0001);
            check("bp_ifpc",  bus.o_if_pc, 32'h10C);
            check("bp_req",   {31'd0, bus.o_instruction_request}, 32'd0);
            check("bp_count", bus.o_fetch_count, 32'd3);
            check("bp_pc",    bus.o_pc, 32'h110);
        end
        bus.i_id_ready = 1'b1;
        tick();
        check("bp_acc", bus.o_fetch_count, 32'd4);
        check("bp_vlo", {31'd0, bus.o_if_valid}, 32'd0);

        // stall freezes the request
        bus.i_stall = 1'b1;
        #1;
        check("stall_req", {31'd0, bus.o_instruction_request}, 32'd0);
        tick();
        check("stall_vld", {31'd0, bus.o_if_valid}, 32'd0);
        check("stall_pc",  bus.o_pc, 32'h110);
        bus.i_stall = 1'b0;

        // redirect wins over a same-cycle ack
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h200;
        #1;
        check("rd_req0", {31'd0, bus.o_instruction_request}, 32'd0);
        tick();
        bus.i_redirect = 1'b0;
        check("rd_vld",  {31'd0, bus.o_if_valid}, 32'd0);
        check("rd_pc",   bus.o_pc, 32'h200);
        check("rd_ifpc", bus.o_if_pc, 32'h10C);
        #1;
        check("rd_req1", {31'd0, bus.o_instruction_request}, 32'd1);

        // redirect in S_FULL with decode ready: no count
        tick();
        check("rdf_vhi", {31'd0, bus.o_if_valid}, 32'd1);
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h300;
        tick();
        check("rdf_vlo",   {31'd0, bus.o_if_valid}, 32'd0);
        check("rdf_count", bus.o_fetch_count, 32'd4);
        check("rdf_pc",    bus.o_pc, 32'h300);

        // pc wraps at the top of the address space
        bus.i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.i_redirect = 1'b0; bus.i_id_ready = 1'b0; bus.i_instruction = 32'h1234_5678;
        tick();
        check("wrap_ifpc", bus.o_if_pc, 32'hFFFF_FFFC);
        check("wrap_pc",   bus.o_pc, 32'h0);
        bus.i_id_ready = 1'b1;
        tick();
        check("wrap_cnt",  bus.o_fetch_count, 32'd5);

        // misaligned redirect
        bus.i_awk = 1'b0; bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h202;
        tick();
        bus.i_redirect = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, bus.o_misalign}, 32'd1);
        check("mis_pc",   bus.o_pc, 32'h202);
        check("mis_req",  {31'd0, bus.o_instruction_request}, 32'd0);
        tick();
        check("mis_hold", {31'd0, bus.o_misalign}, 32'd1);
        check("mis_req2", {31'd0, bus.o_instruction_request}, 32'd0);
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h400;
        tick();
        bus.i_redirect = 1'b0;
        #1;
        check("mis_clr",  {31'd0, bus.o_misalign}, 32'd0);
        check("mis_pc2",  bus.o_pc, 32'h400);
        check("mis_req3", {31'd0, bus.o_instruction_request}, 32'd1);
`else
        check("mis_flag", {31'd0, bus.o_misalign}, 32'd0);
        check("mis_pc",   bus.o_pc, 32'h200);
        check("mis_req",  {31'd0, bus.o_instruction_request}, 32'd1);
`endif

        // reset mid-fetch drops the request without capture
        rst_n = 1'b0; bus.i_awk = 1'b1;
        tick();
        check("rmf_vld",   {31'd0, bus.o_if_valid}, 32'd0);
        check("rmf_instr", bus.o_if_instruction, 32'h13);
        check("rmf_pc",    bus.o_pc, 32'h100);
        check("rmf_cnt",   bus.o_fetch_count, 32'd0);
        check("rmf_req",   {31'd0, bus.o_instruction_request}, 32'd0);
        rst_n = 1'b1; bus.i_awk = 1'b0;
        tick();
        check("rmf_req2",  {31'd0, bus.o_instruction_request}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, first fetch address after reset.
REQ-002 SHALL have port: i_clk  in  1  CPU clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst_n  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port: o_pc  out  32  fetch address to program memory.
REQ-005 SHALL have port: o_instruction_request  out  1  fetch request to program memory.
REQ-006 SHALL have port: i_instruction  in  32  instruction word from program memory.
REQ-007 SHALL have port: i_awk  in  1  program memory acknowledge; i_instruction valid when high.
REQ-008 SHALL have port: o_if_instruction  out  32  instruction to decode.
REQ-009 SHALL have port: o_if_pc  out  32  address of o_if_instruction.
REQ-010 SHALL have port: o_if_valid  out  1  decode output valid.
REQ-011 SHALL have port: i_id_ready  in  1  decode accepts the held instruction.
REQ-012 SHALL have port: i_stall  in  1  pipeline stall; freezes fetch.
REQ-013 SHALL have port: i_redirect  in  1  branch/jump/trap redirect strobe.
REQ-014 SHALL have port: i_redirect_pc  in  32  redirect target.
REQ-015 SHALL have port: o_misalign  out  1  misaligned-redirect flag.
REQ-016 SHALL have port: o_fetch_count  out  32  count of instructions delivered to decode.

Function
REQ-017 SHALL implement states S_IDLE, S_REQ, S_FULL, S_TRAP; registered PC pc_q drives o_pc.
REQ-018 SHALL drive o_instruction_request = (state==S_REQ) && !i_stall && !i_redirect, combinationally.
REQ-019 S_IDLE SHALL go to S_REQ next cycle when i_stall is low, else remain.
REQ-020 S_REQ with request high and i_awk high SHALL capture i_instruction -> o_if_instruction and pc_q -> o_if_pc, set o_if_valid, set pc_q = pc_q+4, and go to S_FULL.
REQ-021 S_REQ with i_awk low SHALL hold the request and pc_q; the wait is unbounded.
REQ-022 S_FULL SHALL hold o_if_* stable; on i_id_ready && !i_stall, clear o_if_valid, increment o_fetch_count, and go to S_REQ; best-case throughput is 1 instruction per 2 cycles.
REQ-023 i_redirect SHALL have priority over i_awk, i_id_ready and i_stall in every state.
REQ-024 On i_redirect, the block SHALL clear o_if_valid, discard any same-cycle ack data, set pc_q = i_redirect_pc, and go to S_REQ.
REQ-025 o_fetch_count SHALL NOT increment on a redirect cycle.
REQ-026 pc_q+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-027 o_fetch_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 An i_awk arriving outside S_REQ SHALL be ignored.

Reset
REQ-029 While i_rst_n is low at a clock edge, the block SHALL load pc_q = RESET_PC, state = S_IDLE, o_if_valid = 0, o_if_instruction = 32'h00000013 (NOP), o_if_pc = 0, o_misalign = 0, o_fetch_count = 0.
REQ-030 Reset SHALL override redirect, ack and stall in the same cycle.
REQ-031 Reset mid-fetch SHALL drop the outstanding request with no capture.
REQ-032 First request SHALL assert on the second edge after i_rst_n rises.

Configuration
REQ-033 Macro FETCH_MISALIGN_TRAP_EN defined:
- A redirect with i_redirect_pc[1:0] != 0 SHALL load pc_q = i_redirect_pc, set o_misalign = 1 (registered), and enter S_TRAP.
- S_TRAP SHALL issue no requests and hold o_misalign high until an aligned redirect, which clears o_misalign and goes to S_REQ.
REQ-034 Macro undefined: the block SHALL force i_redirect_pc[1:0] to 2'b00 when loading pc_q, S_TRAP SHALL be unreachable, and o_misalign SHALL be tied 0.

Verification
REQ-035 Reset release, RESET_PC = 0x100, i_awk = 1 same-cycle, i_id_ready = 1 -> o_pc sequence 0x100, 0x104, 0x108; o_if_valid high every other cycle; o_fetch_count = 3 after third accept.
REQ-036 i_awk held low 5 cycles in S_REQ -> request and o_pc = 0x100 stable 5 cycles; capture on cycle 6.
REQ-037 S_FULL with i_id_ready = 0 for 4 cycles -> o_if_instruction/o_if_pc unchanged, no request, o_fetch_count unchanged.
REQ-038 i_redirect with target 0x200 in the same cycle as i_awk -> ack data discarded, o_if_valid = 0, next o_pc = 0x200.
REQ-039 pc_q = 0xFFFFFFFC fetched -> next o_pc = 0x00000000.
REQ-040 Redirect to 0x202: with FETCH_MISALIGN_TRAP_EN -> o_misalign = 1 and request stays low until an aligned redirect; without it -> o_pc = 0x200 and o_misalign = 0.
